// File: rtl/tlul_data_integ_enc_fifo.sv
// Encodes 32-bit data beats with the inverted 39/32 Hsiao SECDED code and
// queues the {ecc, data} words, plus sideband, in a small FIFO. A one-shot
// XOR mask can be armed to corrupt exactly one future beat.
//
// Handshake: a beat moves on a side only in a cycle where that side's valid
// and ready are both high at the rising clock edge. valid never depends on
// ready, and out_valid_o/out_data_intg_o/out_user_o hold while the head is
// stalled.
module tlul_data_integ_enc_fifo #(
    parameter int Depth    = 2,
    parameter int UserW    = 1,
    parameter bit EnInject = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_data_i,
    input  logic [UserW-1:0] in_user_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [38:0]      out_data_intg_o,
    output logic [UserW-1:0] out_user_o,
    input  logic             inj_req_i,
    input  logic [38:0]      inj_mask_i,
    output logic             inj_pending_o,
    output logic [4:0]       level_o
);

    localparam int          PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam logic [4:0]  DepthL  = 5'(Depth);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

    // Inverted SECDED 39/32 encoder; inversion keeps all-zero words illegal.
    function automatic logic [38:0] secded_inv_39_32_enc(input logic [31:0] d);
        logic [38:0] w;
        w     = {7'd0, d};
        w[32] = ^(w & 39'h00_2606_BD25);
        w[33] = ^(w & 39'h00_DEBA_8050);
        w[34] = ^(w & 39'h00_413D_89AA);
        w[35] = ^(w & 39'h00_3123_4ED1);
        w[36] = ^(w & 39'h00_C2C1_323B);
        w[37] = ^(w & 39'h00_2DCC_624C);
        w[38] = ^(w & 39'h00_9850_5586);
        w     = w ^ 39'h2A_0000_0000;
        return w;
    endfunction

    logic [38:0]      data_mem_q [Depth];
    logic [UserW-1:0] user_mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [4:0]       level_q, level_d;
    logic             armed_q, armed_d;
    logic [38:0]      mask_q, mask_d;
    logic             push, pop;
    logic [38:0]      wr_word;

    assign in_ready_o      = ~rst_i & (level_q != DepthL);
    assign out_valid_o     = (level_q != 5'd0);
    assign push            = in_valid_i & in_ready_o;
    assign pop             = out_valid_o & out_ready_i;
    assign out_data_intg_o = out_valid_o ? data_mem_q[rd_ptr_q] : 39'd0;
    assign out_user_o      = out_valid_o ? user_mem_q[rd_ptr_q] : '0;
    assign inj_pending_o   = armed_q;
    assign level_o         = level_q;

    // Next pointers, occupancy, injection arming and the word to store.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        armed_d  = armed_q;
        mask_d   = mask_q;
        wr_word  = secded_inv_39_32_enc(in_data_i);

        if (push) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;

        case ({push, pop})
            2'b10:   level_d = level_q + 5'd1;
            2'b01:   level_d = level_q - 5'd1;
            default: level_d = level_q;
        endcase

        if (EnInject) begin
            // The armed mask belongs to the first push after arming; a new
            // request in the same cycle re-arms for a later beat.
            if (push && armed_q) begin
                wr_word = wr_word ^ mask_q;
                armed_d = 1'b0;
            end
            if (inj_req_i) begin
                armed_d = 1'b1;
                mask_d  = inj_mask_i;
            end
        end else begin
            armed_d = 1'b0;
            mask_d  = 39'd0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= 5'd0;
            armed_q  <= 1'b0;
            mask_q   <= 39'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            armed_q  <= armed_d;
            mask_q   <= mask_d;
        end
    end

    // FIFO storage, written on push only.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                data_mem_q[i] <= 39'd0;
                user_mem_q[i] <= '0;
            end
        end else if (push) begin
            data_mem_q[wr_ptr_q] <= wr_word;
            user_mem_q[wr_ptr_q] <= in_user_i;
        end
    end

endmodule

// File: tb/tb_tlul_data_integ_enc_fifo.sv
// Directed bench for tlul_data_integ_enc_fifo (Depth=2, UserW=1).
// Expected codewords below were worked out by hand from the SECDED H-matrix.
module tb_tlul_data_integ_enc_fifo;

  localparam logic [38:0] W_ZERO = 39'h2A_0000_0000;
  localparam logic [38:0] W_ONES = 39'h2A_FFFF_FFFF;
  localparam logic [38:0] W_DEAD = 39'h25_DEAD_BEEF;
  localparam logic [38:0] W_B0   = 39'h33_0000_0001;
  localparam logic [38:0] W_B31  = 39'h78_8000_0000;
  localparam logic [38:0] W_B16  = 39'h36_0001_0000;
  localparam logic [38:0] W_MIX  = 39'h7D_8001_0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [0:0]  in_user;
  logic        out_valid;
  logic        out_ready;
  logic [38:0] out_data_intg;
  logic [0:0]  out_user;
  logic        inj_req;
  logic [38:0] inj_mask;
  logic        inj_pending;
  logic [4:0]  level;

  int n_checks = 0;
  int n_fail   = 0;
  logic [39:0] exp_q[$];

  logic [31:0] vec_data [7];
  logic [38:0] vec_word [7];

  // clock / reset
  always #5 clk = ~clk;

  tlul_data_integ_enc_fifo #(
    .Depth(2), .UserW(1), .EnInject(1'b1)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_user_i(in_user),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_intg_o(out_data_intg), .out_user_o(out_user),
    .inj_req_i(inj_req), .inj_mask_i(inj_mask),
    .inj_pending_o(inj_pending), .level_o(level)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: apply inputs at negedge, score the pop/push, advance one cycle
  task automatic step(input logic vin, input logic [31:0] d, input logic u,
                      input logic [38:0] exp_word, input logic rdy,
                      input logic inj, input logic [38:0] msk);
    logic [39:0] head;
    in_valid  = vin;
    in_data   = d;
    in_user   = u;
    out_ready = rdy;
    inj_req   = inj;
    inj_mask  = msk;
    #1;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check_eq("pop_unexpected", {25'd0, out_user, out_data_intg}, 64'd0);
      end else begin
        head = exp_q.pop_front();
        check_eq("pop_word", {25'd0, out_user, out_data_intg}, {24'd0, head});
      end
    end
    if (in_valid && in_ready) exp_q.push_back({u, exp_word});
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    inj_req  = 1'b0;
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (out_valid && budget < 20) begin
      step(1'b0, 32'd0, 1'b0, 39'd0, 1'b1, 1'b0, 39'd0);
      budget++;
    end
    check_eq("drain_level", {59'd0, level}, 64'd0);
    check_eq("drain_queue", exp_q.size(), 64'd0);
  endtask

  initial begin
    vec_data[0] = 32'h0000_0000; vec_word[0] = W_ZERO;
    vec_data[1] = 32'hFFFF_FFFF; vec_word[1] = W_ONES;
    vec_data[2] = 32'hDEAD_BEEF; vec_word[2] = W_DEAD;
    vec_data[3] = 32'h0000_0001; vec_word[3] = W_B0;
    vec_data[4] = 32'h8000_0000; vec_word[4] = W_B31;
    vec_data[5] = 32'h0001_0000; vec_word[5] = W_B16;
    vec_data[6] = 32'h8001_0001; vec_word[6] = W_MIX;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_user = '0;
    out_ready = 1'b0; inj_req = 1'b0; inj_mask = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_pending", inj_pending, 0);
    check_eq("rst_out_data", out_data_intg, 0);
    rst = 1'b0;
    #1;
    check_eq("post_rst_in_ready", in_ready, 1);

    // zero data: one-cycle latency, inverted ecc
    step(1'b1, 32'h0, 1'b0, W_ZERO, 1'b1, 1'b0, 39'd0);
    check_eq("lat_out_valid", out_valid, 1);
    check_eq("lat_out_data", out_data_intg, W_ZERO);
    check_eq("lat_level", level, 1);
    drain();

    // backpressure: fill, hold third beat, then release
    step(1'b1, 32'hFFFF_FFFF, 1'b1, W_ONES, 1'b0, 1'b0, 39'd0);
    step(1'b1, 32'h0000_0001, 1'b0, W_B0, 1'b0, 1'b0, 39'd0);
    check_eq("full_in_ready", in_ready, 0);
    check_eq("full_level", level, 2);
    step(1'b1, 32'h8000_0000, 1'b1, W_B31, 1'b0, 1'b0, 39'd0);
    check_eq("stall_hold_data", out_data_intg, W_ONES);
    check_eq("stall_hold_user", out_user, 1);
    check_eq("stall_level", level, 2);
    step(1'b1, 32'h8000_0000, 1'b1, W_B31, 1'b1, 1'b0, 39'd0);
    check_eq("pop_at_full_level", level, 1);
    step(1'b1, 32'h8000_0000, 1'b1, W_B31, 1'b1, 1'b0, 39'd0);
    check_eq("push_pop_level", level, 1);
    drain();

    // steady push+pop at level 1 for 20 beats
    step(1'b1, vec_data[0], 1'b0, vec_word[0], 1'b1, 1'b0, 39'd0);
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, vec_data[i % 7], 1'(i), vec_word[i % 7], 1'b1, 1'b0, 39'd0);
      check_eq("steady_level", level, 1);
    end
    drain();

    // single-bit injection, next beat clean
    step(1'b0, 32'h0, 1'b0, 39'd0, 1'b1, 1'b1, 39'h1);
    check_eq("inj_armed", inj_pending, 1);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 39'h25_DEAD_BEEE, 1'b1, 1'b0, 39'd0);
    check_eq("inj_consumed", inj_pending, 0);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, W_DEAD, 1'b1, 1'b0, 39'd0);
    drain();

    // push coincident with request is clean; coincident consume re-arms
    step(1'b1, 32'h0, 1'b0, W_ZERO, 1'b1, 1'b1, 39'h3);
    check_eq("coinc_armed", inj_pending, 1);
    step(1'b1, 32'hFFFF_FFFF, 1'b0, 39'h2A_FFFF_FFFC, 1'b1, 1'b1, 39'h1);
    check_eq("rearm_pending", inj_pending, 1);
    step(1'b1, 32'h0000_0001, 1'b1, 39'h33_0000_0000, 1'b1, 1'b0, 39'd0);
    check_eq("rearm_consumed", inj_pending, 0);
    drain();

    // mask overwrite while armed
    step(1'b0, 32'h0, 1'b0, 39'd0, 1'b1, 1'b1, 39'h3);
    step(1'b0, 32'h0, 1'b0, 39'd0, 1'b1, 1'b1, 39'h4);
    step(1'b1, 32'h0001_0000, 1'b0, 39'h36_0001_0004, 1'b1, 1'b0, 39'd0);
    drain();

    // reset mid-operation with full FIFO and armed injection
    step(1'b1, 32'hDEAD_BEEF, 1'b0, W_DEAD, 1'b0, 1'b0, 39'd0);
    step(1'b1, 32'h0000_0001, 1'b0, W_B0, 1'b0, 1'b1, 39'h1);
    check_eq("pre_rst_level", level, 2);
    check_eq("pre_rst_pending", inj_pending, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_out_valid", out_valid, 0);
    check_eq("mid_rst_level", level, 0);
    check_eq("mid_rst_pending", inj_pending, 0);
    check_eq("mid_rst_in_ready", in_ready, 0);
    check_eq("mid_rst_out_data", out_data_intg, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("after_rst_in_ready", in_ready, 1);
    @(negedge clk);
    step(1'b1, 32'h8001_0001, 1'b1, W_MIX, 1'b1, 1'b0, 39'd0);
    check_eq("after_rst_data", out_data_intg, W_MIX);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
